// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - packet type and requester/memory bundle for mem_arbiter
package mem_arbiter_pkg;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_pkt_t;
endpackage

interface mem_arbiter_if #(
    parameter int MAX_OUTSTANDING = 4
) ();
    import mem_arbiter_pkg::*;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic          imem_req_vld;
    logic          imem_req_rdy;
    mem_pkt_t      imem_req;
    logic          imem_rsp_vld;
    logic          imem_rsp_rdy;
    mem_pkt_t      imem_rsp;
    logic          dmem_req_vld;
    logic          dmem_req_rdy;
    mem_pkt_t      dmem_req;
    logic          dmem_rsp_vld;
    logic          dmem_rsp_rdy;
    mem_pkt_t      dmem_rsp;
    logic          mem_req_vld;
    logic          mem_req_rdy;
    mem_pkt_t      mem_req;
    logic          mem_rsp_vld;
    logic          mem_rsp_rdy;
    mem_pkt_t      mem_rsp;
    logic [CW-1:0] outstanding;
    logic          arb_err;

    modport slave (
        input  imem_req_vld, imem_req, imem_rsp_rdy,
        input  dmem_req_vld, dmem_req, dmem_rsp_rdy,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp,
        output imem_req_rdy, imem_rsp_vld, imem_rsp,
        output dmem_req_rdy, dmem_rsp_vld, dmem_rsp,
        output mem_req_vld, mem_req, mem_rsp_rdy,
        output outstanding, arb_err
    );

    modport master (
        output imem_req_vld, imem_req, imem_rsp_rdy,
        output dmem_req_vld, dmem_req, dmem_rsp_rdy,
        output mem_req_rdy, mem_rsp_vld, mem_rsp,
        input  imem_req_rdy, imem_rsp_vld, imem_rsp,
        input  dmem_req_rdy, dmem_rsp_vld, dmem_rsp,
        input  mem_req_vld, mem_req, mem_rsp_rdy,
        input  outstanding, arb_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - imem/dmem arbiter onto one memory port with in-order response routing
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);
    localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     state_q, state_d;
    logic                       grant_q, grant_d;
    logic [3:0]                 starve_cnt_q, starve_cnt_d;
    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic                       arb_err_q;

    // grant: 1 selects dmem, 0 selects imem; the same encoding is stored as the tag
    logic grant;
    logic full;
    logic empty;
    logic req_vld;
    logic req_accept;
    logic head_is_dmem;
    logic rsp_rdy;
    logic rsp_pop;
    logic rsp_drop;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_cnt_d = starve_cnt_q;
        count_d      = count_q;
        full         = (count_q == MAX_CNT);
        empty        = (count_q == '0);

        if (state_q == LOCKED) begin
            grant = grant_q;
        end else begin
            grant = bus.dmem_req_vld &&
                    !((starve_cnt_q == STARVE_MAX) && bus.imem_req_vld);
        end

        // rst_n gating keeps every request-side valid/ready low during reset
        req_vld    = rst_n && !full && (grant ? bus.dmem_req_vld : bus.imem_req_vld);
        req_accept = req_vld && bus.mem_req_rdy;

        case (state_q)
            IDLE: begin
                if (req_vld && !bus.mem_req_rdy) begin
                    state_d = LOCKED;
                    grant_d = grant;
                end
            end
            LOCKED: begin
                if (bus.mem_req_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_accept) begin
            if (grant && bus.imem_req_vld) begin
                if (starve_cnt_q != STARVE_MAX) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end else begin
                starve_cnt_d = 4'd0;
            end
        end

        head_is_dmem = tag_q[rd_ptr_q];
        rsp_rdy      = empty || (head_is_dmem ? bus.dmem_rsp_rdy : bus.imem_rsp_rdy);
        rsp_pop      = bus.mem_rsp_vld && rsp_rdy && !empty;
        rsp_drop     = bus.mem_rsp_vld && empty;

        if (req_accept && !rsp_pop) begin
            count_d = count_q + 1'b1;
        end else if (rsp_pop && !req_accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            starve_cnt_q <= 4'd0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_cnt_q <= starve_cnt_d;
            count_q      <= count_d;
            if (req_accept) begin
                tag_q[wr_ptr_q] <= grant;
                wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rsp_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (rsp_drop) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req_vld  = req_vld;
    assign bus.mem_req      = grant ? bus.dmem_req : bus.imem_req;
    assign bus.imem_req_rdy = req_accept && !grant;
    assign bus.dmem_req_rdy = req_accept && grant;

    assign bus.mem_rsp_rdy  = rsp_rdy;
    assign bus.imem_rsp_vld = bus.mem_rsp_vld && !empty && !head_is_dmem;
    assign bus.dmem_rsp_vld = bus.mem_rsp_vld && !empty && head_is_dmem;
    assign bus.imem_rsp     = bus.mem_rsp;
    assign bus.dmem_rsp     = bus.mem_rsp;

    assign bus.outstanding  = count_q;
    assign bus.arb_err      = arb_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scenarios and randomized model comparison for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXO  = 4;
    localparam int LIMIT = 3;
    localparam int CW    = $clog2(MAXO + 1);

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mem_arbiter_if #(.MAX_OUTSTANDING(MAXO)) bus ();

    mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic mem_pkt_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_pkt_t p;
        p.we   = we;
        p.addr = a;
        p.data = d;
        return p;
    endfunction

    task automatic idle_inputs();
        bus.imem_req_vld = 1'b0; bus.imem_req = '0; bus.imem_rsp_rdy = 1'b1;
        bus.dmem_req_vld = 1'b0; bus.dmem_req = '0; bus.dmem_rsp_rdy = 1'b1;
        bus.mem_req_rdy  = 1'b0; bus.mem_rsp_vld = 1'b0; bus.mem_rsp = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_req_vld = 1'b1; bus.dmem_req_vld = 1'b1;
        bus.mem_req_rdy = 1'b1; bus.mem_rsp_vld = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.mem_req_vld !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_vld got %b want 0", bus.mem_req_vld); end
        n_vec++; if (bus.imem_req_rdy !== 1'b0 || bus.dmem_req_rdy !== 1'b0) begin n_err++; $display("FAIL reset_req_rdy got %b%b want 00", bus.imem_req_rdy, bus.dmem_req_rdy); end
        n_vec++; if (bus.imem_rsp_vld !== 1'b0 || bus.dmem_rsp_vld !== 1'b0) begin n_err++; $display("FAIL reset_rsp_vld got %b%b want 00", bus.imem_rsp_vld, bus.dmem_rsp_vld); end
        n_vec++; if (bus.mem_rsp_rdy !== 1'b1) begin n_err++; $display("FAIL reset_mem_rsp_rdy got %b want 1", bus.mem_rsp_rdy); end
        n_vec++; if (bus.outstanding !== CW'(0) || bus.arb_err !== 1'b0) begin n_err++; $display("FAIL reset_state outstanding %0d arb_err %b want 0 0", bus.outstanding, bus.arb_err); end
        idle_inputs();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_imem();
        mem_pkt_t p;
        p = mk(1'b0, 32'h0000_1000, 32'h0);
        do_reset();
        bus.imem_req_vld = 1'b1; bus.imem_req = p; bus.mem_req_rdy = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.mem_req_vld !== 1'b1 || bus.mem_req !== p) begin n_err++; $display("FAIL single_req vld %b pkt %h want 1 %h", bus.mem_req_vld, bus.mem_req, p); end
        n_vec++; if (bus.imem_req_rdy !== 1'b1 || bus.dmem_req_rdy !== 1'b0) begin n_err++; $display("FAIL single_rdy got %b%b want 10", bus.imem_req_rdy, bus.dmem_req_rdy); end
        @(posedge clk); #1 bus.imem_req_vld = 1'b0; bus.mem_req_rdy = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.outstanding !== CW'(1)) begin n_err++; $display("FAIL single_outstanding got %0d want 1", bus.outstanding); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b1; bus.mem_rsp = mk(1'b0, 32'h0, 32'h0000_0013);
        @(negedge clk);
        n_vec++; if (bus.imem_rsp_vld !== 1'b1 || bus.dmem_rsp_vld !== 1'b0) begin n_err++; $display("FAIL single_rsp_vld got %b%b want 10", bus.imem_rsp_vld, bus.dmem_rsp_vld); end
        n_vec++; if (bus.imem_rsp.data !== 32'h0000_0013) begin n_err++; $display("FAIL single_rsp_data got %h want 00000013", bus.imem_rsp.data); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.outstanding !== CW'(0)) begin n_err++; $display("FAIL single_drain got %0d want 0", bus.outstanding); end
    endtask

    task automatic test_priority_starve();
        logic [7:0] pat;
        int         tb_out;
        pat = 8'b0111_0111;
        tb_out = 0;
        do_reset();
        bus.imem_req_vld = 1'b1; bus.imem_req = mk(1'b0, 32'h1111_0000, 32'h0);
        bus.dmem_req_vld = 1'b1; bus.dmem_req = mk(1'b1, 32'hDDDD_0000, 32'h5);
        bus.mem_req_rdy  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.mem_rsp_vld = (tb_out > 0);
            @(negedge clk);
            n_vec++; if (bus.dmem_req_rdy !== pat[k] || bus.imem_req_rdy !== !pat[k]) begin n_err++; $display("FAIL prio_grant%0d got d%b i%b want d%b", k, bus.dmem_req_rdy, bus.imem_req_rdy, pat[k]); end
            @(posedge clk); #1;
            tb_out = tb_out + 1 - ((tb_out > 0) ? 1 : 0);
        end
    endtask

    task automatic test_lock();
        mem_pkt_t pd, pi;
        pd = mk(1'b1, 32'hD000_0040, 32'hCAFE_0001);
        pi = mk(1'b0, 32'h1000_0080, 32'h0);
        do_reset();
        bus.dmem_req_vld = 1'b1; bus.dmem_req = pd; bus.imem_req = pi;
        for (int k = 1; k <= 4; k++) begin
            bus.mem_req_rdy = (k == 4);
            @(negedge clk);
            n_vec++; if (bus.mem_req_vld !== 1'b1 || bus.mem_req !== pd) begin n_err++; $display("FAIL lock_hold%0d vld %b pkt %h want 1 %h", k, bus.mem_req_vld, bus.mem_req, pd); end
            n_vec++; if (bus.dmem_req_rdy !== (k == 4) || bus.imem_req_rdy !== 1'b0) begin n_err++; $display("FAIL lock_rdy%0d got d%b i%b", k, bus.dmem_req_rdy, bus.imem_req_rdy); end
            @(posedge clk); #1 bus.imem_req_vld = 1'b1;
        end
        bus.dmem_req_vld = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.imem_req_rdy !== 1'b1 || bus.mem_req !== pi) begin n_err++; $display("FAIL lock_next rdy %b pkt %h want 1 %h", bus.imem_req_rdy, bus.mem_req, pi); end
        @(posedge clk); #1 bus.imem_req_vld = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        bus.imem_req_vld = 1'b1; bus.imem_req = mk(1'b0, 32'h2000, 32'h0); bus.mem_req_rdy = 1'b1;
        for (int k = 0; k < MAXO; k++) begin
            @(negedge clk);
            n_vec++; if (bus.imem_req_rdy !== 1'b1) begin n_err++; $display("FAIL full_fill%0d rdy %b want 1", k, bus.imem_req_rdy); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_vec++; if (bus.imem_req_rdy !== 1'b0 || bus.mem_req_vld !== 1'b0 || bus.outstanding !== CW'(MAXO)) begin n_err++; $display("FAIL full_block rdy %b vld %b out %0d want 0 0 %0d", bus.imem_req_rdy, bus.mem_req_vld, bus.outstanding, MAXO); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.imem_req_rdy !== 1'b0 || bus.imem_rsp_vld !== 1'b1) begin n_err++; $display("FAIL full_pop_cycle req_rdy %b rsp_vld %b want 0 1", bus.imem_req_rdy, bus.imem_rsp_vld); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.outstanding !== CW'(MAXO - 1) || bus.imem_req_rdy !== 1'b1) begin n_err++; $display("FAIL full_resume out %0d rdy %b want %0d 1", bus.outstanding, bus.imem_req_rdy, MAXO - 1); end
        @(posedge clk); #1 bus.imem_req_vld = 1'b0;
    endtask

    task automatic test_ordering();
        do_reset();
        bus.mem_req_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.imem_req_vld = (k != 1); bus.dmem_req_vld = (k == 1);
            bus.imem_req = mk(1'b0, 32'(k), 32'h0); bus.dmem_req = mk(1'b1, 32'(k), 32'h0);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        n_vec++; if (bus.outstanding !== CW'(3)) begin n_err++; $display("FAIL order_out got %0d want 3", bus.outstanding); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b1; bus.mem_rsp = mk(1'b0, 32'h0, 32'h1); bus.dmem_rsp_rdy = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.imem_rsp_vld !== 1'b1 || bus.dmem_rsp_vld !== 1'b0 || bus.imem_rsp.data !== 32'h1) begin n_err++; $display("FAIL order_rsp0 i%b d%b data %h want 1 0 1", bus.imem_rsp_vld, bus.dmem_rsp_vld, bus.imem_rsp.data); end
        @(posedge clk); #1 bus.mem_rsp = mk(1'b0, 32'h0, 32'h2);
        @(negedge clk);
        n_vec++; if (bus.dmem_rsp_vld !== 1'b1 || bus.imem_rsp_vld !== 1'b0 || bus.mem_rsp_rdy !== 1'b0) begin n_err++; $display("FAIL order_stall d%b i%b rdy %b want 1 0 0", bus.dmem_rsp_vld, bus.imem_rsp_vld, bus.mem_rsp_rdy); end
        @(posedge clk); #1 bus.dmem_rsp_rdy = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.mem_rsp_rdy !== 1'b1 || bus.dmem_rsp.data !== 32'h2) begin n_err++; $display("FAIL order_rsp1 rdy %b data %h want 1 2", bus.mem_rsp_rdy, bus.dmem_rsp.data); end
        @(posedge clk); #1 bus.mem_rsp = mk(1'b0, 32'h0, 32'h3);
        @(negedge clk);
        n_vec++; if (bus.imem_rsp_vld !== 1'b1 || bus.dmem_rsp_vld !== 1'b0 || bus.imem_rsp.data !== 32'h3) begin n_err++; $display("FAIL order_rsp2 i%b d%b data %h want 1 0 3", bus.imem_rsp_vld, bus.dmem_rsp_vld, bus.imem_rsp.data); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.outstanding !== CW'(0)) begin n_err++; $display("FAIL order_drain got %0d want 0", bus.outstanding); end
    endtask

    task automatic test_error_reset();
        do_reset();
        bus.mem_rsp_vld = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.mem_rsp_rdy !== 1'b1 || bus.imem_rsp_vld !== 1'b0 || bus.dmem_rsp_vld !== 1'b0) begin n_err++; $display("FAIL err_drop rdy %b i%b d%b want 1 0 0", bus.mem_rsp_rdy, bus.imem_rsp_vld, bus.dmem_rsp_vld); end
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b0; bus.imem_req_vld = 1'b1; bus.mem_req_rdy = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.arb_err !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", bus.arb_err); end
        @(posedge clk); #1;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        n_vec++; if (bus.outstanding !== CW'(2) || bus.arb_err !== 1'b1) begin n_err++; $display("FAIL err_sticky out %0d err %b want 2 1", bus.outstanding, bus.arb_err); end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.outstanding !== CW'(0) || bus.arb_err !== 1'b0) begin n_err++; $display("FAIL err_async_reset out %0d err %b want 0 0", bus.outstanding, bus.arb_err); end
        @(posedge clk); #1 rst_n = 1'b1; bus.mem_rsp_vld = 1'b1;
        @(posedge clk); #1 bus.mem_rsp_vld = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.arb_err !== 1'b1) begin n_err++; $display("FAIL err_after_reset got %b want 1", bus.arb_err); end
    endtask

    task automatic test_random();
        bit       tagq[$];
        int       starve, lock_src, g, sz;
        bit       errm, i_hold, d_hold, full_m, empty_m;
        bit       e_req_vld, e_acc, e_i_rdy, e_d_rdy, e_rsp_rdy, e_i_rsp, e_d_rsp, e_pop;
        mem_pkt_t e_pkt, rsp_pkt;
        do_reset();
        starve = 0; lock_src = -1; errm = 0; i_hold = 0; d_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sz = tagq.size();
            if (!i_hold) begin
                bus.imem_req_vld = ($urandom_range(0, 9) < 6);
                bus.imem_req = mk(1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            if (!d_hold) begin
                bus.dmem_req_vld = ($urandom_range(0, 9) < 6);
                bus.dmem_req = mk(1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            bus.mem_req_rdy  = ($urandom_range(0, 9) < 7);
            bus.mem_rsp_vld  = (sz > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
            rsp_pkt          = mk(1'($urandom_range(0, 1)), $urandom, $urandom);
            bus.mem_rsp      = rsp_pkt;
            bus.imem_rsp_rdy = ($urandom_range(0, 9) < 7);
            bus.dmem_rsp_rdy = ($urandom_range(0, 9) < 7);
            @(negedge clk);

            full_m  = (sz == MAXO);
            empty_m = (sz == 0);
            if (lock_src >= 0) g = lock_src;
            else if (bus.dmem_req_vld && !(starve == LIMIT && bus.imem_req_vld)) g = 1;
            else if (bus.imem_req_vld) g = 0;
            else g = -1;
            e_req_vld = (g >= 0) && !full_m;
            e_pkt     = (g == 1) ? bus.dmem_req : bus.imem_req;
            e_acc     = e_req_vld && bus.mem_req_rdy;
            e_i_rdy   = e_acc && (g == 0);
            e_d_rdy   = e_acc && (g == 1);
            e_rsp_rdy = empty_m ? 1'b1 : (tagq[0] ? bus.dmem_rsp_rdy : bus.imem_rsp_rdy);
            e_i_rsp   = bus.mem_rsp_vld && !empty_m && !tagq[0];
            e_d_rsp   = bus.mem_rsp_vld && !empty_m && tagq[0];
            e_pop     = bus.mem_rsp_vld && e_rsp_rdy && !empty_m;

            n_vec++; if (bus.mem_req_vld !== e_req_vld) begin n_err++; $display("FAIL rnd%0d mem_req_vld got %b want %b", cyc, bus.mem_req_vld, e_req_vld); end
            n_vec++; if (bus.imem_req_rdy !== e_i_rdy || bus.dmem_req_rdy !== e_d_rdy) begin n_err++; $display("FAIL rnd%0d req_rdy got i%b d%b want i%b d%b", cyc, bus.imem_req_rdy, bus.dmem_req_rdy, e_i_rdy, e_d_rdy); end
            if (e_req_vld) begin
                n_vec++; if (bus.mem_req !== e_pkt) begin n_err++; $display("FAIL rnd%0d mem_req got %h want %h", cyc, bus.mem_req, e_pkt); end
            end
            n_vec++; if (bus.mem_rsp_rdy !== e_rsp_rdy) begin n_err++; $display("FAIL rnd%0d mem_rsp_rdy got %b want %b", cyc, bus.mem_rsp_rdy, e_rsp_rdy); end
            n_vec++; if (bus.imem_rsp_vld !== e_i_rsp || bus.dmem_rsp_vld !== e_d_rsp) begin n_err++; $display("FAIL rnd%0d rsp_vld got i%b d%b want i%b d%b", cyc, bus.imem_rsp_vld, bus.dmem_rsp_vld, e_i_rsp, e_d_rsp); end
            if (e_i_rsp || e_d_rsp) begin
                n_vec++; if ((e_i_rsp ? bus.imem_rsp : bus.dmem_rsp) !== rsp_pkt) begin n_err++; $display("FAIL rnd%0d rsp_pkt want %h", cyc, rsp_pkt); end
            end
            n_vec++; if (bus.outstanding !== CW'(sz) || bus.arb_err !== errm) begin n_err++; $display("FAIL rnd%0d state out %0d err %b want %0d %b", cyc, bus.outstanding, bus.arb_err, sz, errm); end

            if (e_pop) void'(tagq.pop_front());
            if (bus.mem_rsp_vld && empty_m) errm = 1'b1;
            if (e_acc) begin
                tagq.push_back(g == 1);
                if (g == 1 && bus.imem_req_vld) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
                else starve = 0;
            end
            lock_src = (e_req_vld && !bus.mem_req_rdy) ? g : -1;
            i_hold   = bus.imem_req_vld && !e_i_rdy;
            d_hold   = bus.dmem_req_vld && !e_d_rdy;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        test_reset();
        test_single_imem();
        test_priority_starve();
        test_lock();
        test_full();
        test_ordering();
        test_error_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
